// File: rtl/dm_sba_ctrl.sv
// -----------------------------------------------------------------------------
// dm_sba_ctrl -- system bus access engine for the debug module.
//
// Launches single read/write transfers on a req/gnt/r_valid bus master port
// on behalf of the debug CSR file. At launch it captures the address, access
// size, autoincrement flag and write data. Read data is returned registered,
// right-aligned and zero-extended above the access size. Busy, size,
// alignment, bus error and (optionally) timeout conditions are reported.
//
// Configuration macro:
//   DM_SBA_TIMEOUT_EN  - when defined, a per-transfer cycle counter aborts a
//                        transfer after TimeoutCycles with error code 1.
//                        When undefined, the engine waits indefinitely.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   dmactive_i                 low = synchronous clear of all state
//   master_*                   bus master port (req/add/we/wdata/be, gnt,
//                              r_valid/r_err/r_rdata)
//   sbaddress_i, sbdata_i      CSR address / write data
//   sb*_valid_i, sbreadon*_i   trigger sources from the CSR file
//   sbaccess_i                 log2 of access size in bytes
//   sbautoincrement_i          bump address after a successful transfer
//   sberror_pending_i          CSR sberror nonzero; triggers ignored
//   sbaddress_o/_upd_o         incremented address and its load pulse
//   sbdata_o/_valid_o          read data and its valid pulse
//   sbbusy_o, sbbusyerror_o    transfer in progress / trigger while busy
//   sberror_o/_valid_o         error code and its valid pulse
// -----------------------------------------------------------------------------
module dm_sba_ctrl #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dmactive_i,

    output logic                    master_req_o,
    output logic [AddrWidth-1:0]    master_add_o,
    output logic                    master_we_o,
    output logic [BusWidth-1:0]     master_wdata_o,
    output logic [BusWidth/8-1:0]   master_be_o,
    input  logic                    master_gnt_i,
    input  logic                    master_r_valid_i,
    input  logic                    master_r_err_i,
    input  logic [BusWidth-1:0]     master_r_rdata_i,

    input  logic [AddrWidth-1:0]    sbaddress_i,
    input  logic                    sbaddress_write_valid_i,
    input  logic                    sbreadonaddr_i,
    input  logic                    sbautoincrement_i,
    input  logic [2:0]              sbaccess_i,
    input  logic                    sbreadondata_i,
    input  logic [BusWidth-1:0]     sbdata_i,
    input  logic                    sbdata_read_valid_i,
    input  logic                    sbdata_write_valid_i,
    input  logic                    sberror_pending_i,

    output logic [AddrWidth-1:0]    sbaddress_o,
    output logic                    sbaddress_upd_o,
    output logic [BusWidth-1:0]     sbdata_o,
    output logic                    sbdata_valid_o,
    output logic                    sbbusy_o,
    output logic                    sbbusyerror_o,
    output logic                    sberror_valid_o,
    output logic [2:0]              sberror_o
);

    localparam int unsigned BeWidth  = BusWidth / 8;
    localparam int unsigned OffWidth = $clog2(BeWidth);

    localparam logic [2:0] ErrTimeout = 3'd1;
    localparam logic [2:0] ErrBus     = 3'd2;
    localparam logic [2:0] ErrAlign   = 3'd3;
    localparam logic [2:0] ErrSize    = 3'd4;

    // Elaboration-time guard against unsupported configurations.
    if (!(BusWidth == 32 || BusWidth == 64 || BusWidth == 128) ||
        AddrWidth < 32 || AddrWidth > 64 || TimeoutCycles < 1) begin : g_param_check
        $error("dm_sba_ctrl: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        Idle,
        Read,
        Write,
        WaitRead,
        WaitWrite
    } state_e;

    state_e r_state, w_state_next;

    // Operands captured at launch.
    logic [AddrWidth-1:0] r_addr;
    logic [2:0]           r_size;
    logic                 r_autoinc;
    logic [BusWidth-1:0]  r_wdata;

    // Registered CSR-side results.
    logic [AddrWidth-1:0] r_sbaddress;
    logic                 r_sbaddress_upd;
    logic [BusWidth-1:0]  r_sbdata;
    logic                 r_sbdata_valid;
    logic                 r_sbbusyerror;
    logic                 r_sberror_valid;
    logic [2:0]           r_sberror;

    logic                 w_trig_write, w_trig_rdata, w_trig_raddr, w_any_trig;
    logic                 w_size_err, w_align_err;
    logic [AddrWidth-1:0] w_align_mask;
    logic                 w_launch_ok, w_launch_err, w_busy_trig;
    logic                 w_in_wait, w_rsp, w_timeout;
    logic [OffWidth-1:0]  w_offset;
    logic [BeWidth-1:0]   w_be_base, w_be;
    logic [BusWidth-1:0]  w_size_mask;

    // ------------------------------------------------------------------
    // Trigger decode and launch checks
    // ------------------------------------------------------------------
    assign w_trig_write = sbdata_write_valid_i;
    assign w_trig_rdata = sbdata_read_valid_i & sbreadondata_i;
    assign w_trig_raddr = sbaddress_write_valid_i & sbreadonaddr_i;
    assign w_any_trig   = (w_trig_write | w_trig_rdata | w_trig_raddr) & ~sberror_pending_i;

    assign w_size_err   = (32'd8 << sbaccess_i) > 32'(BusWidth);
    assign w_align_mask = (AddrWidth'(1) << sbaccess_i) - AddrWidth'(1);
    assign w_align_err  = |(sbaddress_i & w_align_mask);

    assign w_launch_ok  = (r_state == Idle) & w_any_trig & ~w_size_err & ~w_align_err;
    assign w_launch_err = (r_state == Idle) & w_any_trig & (w_size_err | w_align_err);
    assign w_busy_trig  = (r_state != Idle) & w_any_trig;

    assign w_in_wait    = (r_state == WaitRead) | (r_state == WaitWrite);
    assign w_rsp        = w_in_wait & master_r_valid_i;

    // ------------------------------------------------------------------
    // Optional transfer timeout
    // ------------------------------------------------------------------
`ifdef DM_SBA_TIMEOUT_EN
    localparam int unsigned TimerWidth = $clog2(TimeoutCycles + 1);
    logic [TimerWidth-1:0] r_timer;

    // Counts cycles spent outside Idle; the abort fires on the edge where the
    // count would reach TimeoutCycles, unless a response completes first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timer <= '0;
        end else if (!dmactive_i || w_launch_ok) begin
            r_timer <= '0;
        end else if (r_state != Idle) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timeout = (r_state != Idle) & ~w_rsp &
                       (r_timer == TimerWidth'(TimeoutCycles - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= Idle;
        end else if (!dmactive_i) begin
            r_state <= Idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next state gets its default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            Idle: begin
                if (w_launch_ok) begin
                    w_state_next = w_trig_write ? Write : Read;
                end
            end
            Read:      if (master_gnt_i)     w_state_next = WaitRead;
            Write:     if (master_gnt_i)     w_state_next = WaitWrite;
            WaitRead:  if (master_r_valid_i) w_state_next = Idle;
            WaitWrite: if (master_r_valid_i) w_state_next = Idle;
            default:                         w_state_next = Idle;
        endcase
        if (w_timeout) begin
            w_state_next = Idle;
        end
    end

    // ------------------------------------------------------------------
    // Byte-lane steering from the captured operands
    // ------------------------------------------------------------------
    assign w_offset = r_addr[OffWidth-1:0];

    always_comb begin
        w_be_base = '0;
        for (int unsigned i = 0; i < BeWidth; i++) begin
            if (i < (32'd1 << r_size)) w_be_base[i] = 1'b1;
        end
        w_be = w_be_base << w_offset;
    end

    always_comb begin
        w_size_mask = '0;
        for (int unsigned i = 0; i < BusWidth; i++) begin
            if (i < (32'd8 << r_size)) w_size_mask[i] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, completion and error reporting
    // ------------------------------------------------------------------
    // NOTE: the data registers are reset too, because every output must read
    // zero out of reset and dmactive clears them to the same values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr          <= '0;
            r_size          <= '0;
            r_autoinc       <= 1'b0;
            r_wdata         <= '0;
            r_sbaddress     <= '0;
            r_sbaddress_upd <= 1'b0;
            r_sbdata        <= '0;
            r_sbdata_valid  <= 1'b0;
            r_sbbusyerror   <= 1'b0;
            r_sberror_valid <= 1'b0;
            r_sberror       <= '0;
        end else if (!dmactive_i) begin
            r_addr          <= '0;
            r_size          <= '0;
            r_autoinc       <= 1'b0;
            r_wdata         <= '0;
            r_sbaddress     <= '0;
            r_sbaddress_upd <= 1'b0;
            r_sbdata        <= '0;
            r_sbdata_valid  <= 1'b0;
            r_sbbusyerror   <= 1'b0;
            r_sberror_valid <= 1'b0;
            r_sberror       <= '0;
        end else begin
            r_sbaddress_upd <= 1'b0;
            r_sbdata_valid  <= 1'b0;
            r_sberror_valid <= 1'b0;
            r_sbbusyerror   <= w_busy_trig;

            if (w_launch_err) begin
                r_sberror_valid <= 1'b1;
                r_sberror       <= w_size_err ? ErrSize : ErrAlign;
            end

            if (w_launch_ok) begin
                r_addr    <= sbaddress_i;
                r_size    <= sbaccess_i;
                r_autoinc <= sbautoincrement_i;
                r_wdata   <= sbdata_i;
            end

            if (w_rsp) begin
                if (master_r_err_i) begin
                    r_sberror_valid <= 1'b1;
                    r_sberror       <= ErrBus;
                end else begin
                    if (r_state == WaitRead) begin
                        r_sbdata       <= (master_r_rdata_i >> {w_offset, 3'b000}) & w_size_mask;
                        r_sbdata_valid <= 1'b1;
                    end
                    if (r_autoinc) begin
                        r_sbaddress     <= r_addr + (AddrWidth'(1) << r_size);
                        r_sbaddress_upd <= 1'b1;
                    end
                end
            end

            if (w_timeout) begin
                r_sberror_valid <= 1'b1;
                r_sberror       <= ErrTimeout;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bus signals are driven only while a transfer is in flight
    // ------------------------------------------------------------------
    assign sbbusy_o        = (r_state != Idle);
    assign master_req_o    = (r_state == Read) | (r_state == Write);
    assign master_we_o     = (r_state == Write) | (r_state == WaitWrite);
    assign master_add_o    = sbbusy_o ? {r_addr[AddrWidth-1:OffWidth], {OffWidth{1'b0}}} : '0;
    assign master_be_o     = sbbusy_o ? w_be : '0;
    assign master_wdata_o  = sbbusy_o ? (r_wdata << {w_offset, 3'b000}) : '0;

    assign sbaddress_o     = r_sbaddress;
    assign sbaddress_upd_o = r_sbaddress_upd;
    assign sbdata_o        = r_sbdata;
    assign sbdata_valid_o  = r_sbdata_valid;
    assign sbbusyerror_o   = r_sbbusyerror;
    assign sberror_valid_o = r_sberror_valid;
    assign sberror_o       = r_sberror;

endmodule

// File: doc/dm_sba_ctrl.md
# dm_sba_ctrl

Parametrised system bus access engine for the debug module. It sits between the debug CSR file and a req/gnt/r_valid system bus master port. It generalises the earlier SBA block with several additions:
- independent address and data widths, with data up to 128 bit;
- operand capture at launch;
- registered, size-extracted read data;
- full debug-spec error reporting: busy, size, alignment, bus error, and an optional timeout.

## Interface
Parameters:
- AddrWidth, 32, system bus address width (32..64)
- BusWidth, 32, bus data width; legal values 32, 64, 128
- TimeoutCycles, 1024, cycles allowed per transfer when the timeout is compiled in

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmactive_i  in  1  low = synchronous clear of all state to reset values
- master_req_o  out  1  bus request
- master_add_o  out  AddrWidth  captured address, BusWidth/8-aligned
- master_we_o  out  1  write enable
- master_wdata_o  out  BusWidth  write data, shifted to byte lane
- master_be_o  out  BusWidth/8  byte enables (reads and writes)
- master_gnt_i  in  1  grant
- master_r_valid_i  in  1  response valid (reads and writes)
- master_r_err_i  in  1  response carries bus error; qualified by r_valid
- master_r_rdata_i  in  BusWidth  read data
- sbaddress_i  in  AddrWidth  CSR address
- sbaddress_write_valid_i  in  1  debugger wrote sbaddress
- sbreadonaddr_i  in  1  read on address write
- sbautoincrement_i  in  1  increment address after success
- sbaccess_i  in  3  log2 access bytes
- sbreadondata_i  in  1  read on sbdata read
- sbdata_i  in  BusWidth  CSR write data
- sbdata_read_valid_i  in  1  debugger read sbdata
- sbdata_write_valid_i  in  1  debugger wrote sbdata
- sberror_pending_i  in  1  CSR sberror nonzero; new triggers ignored
- sbaddress_o  out  AddrWidth  incremented address
- sbaddress_upd_o  out  1  pulse: load sbaddress_o into CSR
- sbdata_o  out  BusWidth  read data, right-aligned, zero-extended above access size
- sbdata_valid_o  out  1  pulse: sbdata_o valid
- sbbusy_o  out  1  transfer in progress
- sbbusyerror_o  out  1  pulse: trigger arrived while busy
- sberror_valid_o  out  1  pulse: sberror_o valid
- sberror_o  out  3  error code

All outputs reset to 0.

## Operation
States are Idle, Read, Write, WaitRead and WaitWrite. Only Idle asserts nothing; sbbusy_o = (state != Idle).

Triggers in Idle:
- Priority: write (sbdata_write_valid_i) > read on data (sbdata_read_valid_i & sbreadondata_i) > read on address (sbaddress_write_valid_i & sbreadonaddr_i).
- Simultaneous triggers launch one transfer only; the rest are dropped silently.
- Any trigger is ignored while sberror_pending_i is high.

Launch checks, in priority order. On failure the block stays in Idle and issues no bus request:
- 8<<sbaccess_i > BusWidth → error code 4 (size).
- Address not aligned to 1<<sbaccess_i → error code 3 (alignment).

On launch the block captures address, sbaccess_i, sbautoincrement_i and sbdata_i into registers. Later CSR changes do not affect the transfer in flight.

Byte lanes:
- offset = captured address[log2(BusWidth/8)-1:0].
- master_be_o = ((1<<(1<<size))-1) << offset.
- master_wdata_o = data << 8*offset.

Bus handshake:
- Read/Write hold master_req_o high with stable add/we/be/wdata until master_gnt_i, then move to WaitRead/WaitWrite.
- In the Wait states, master_r_valid_i completes the transfer and returns to Idle.
- If r_err is set with r_valid → error code 2, no data, no increment.

Read completion:
- sbdata_o register = (rdata >> 8*offset), masked to the access size.
- sbdata_valid_o pulses for one cycle.

Completion without error, when the captured autoincrement is set:
- sbaddress_o = captured address + (1<<size), modulo 2^AddrWidth (wraps).
- sbaddress_upd_o pulses for one cycle.

Busy and spurious inputs:
- Any trigger while not in Idle → sbbusyerror_o pulse; the trigger is discarded and the transfer in flight is unaffected.
- master_r_valid_i outside the Wait states is ignored.

## Timing
- Trigger in cycle T → master_req_o high from T+1. Launch errors pulse sberror_valid_o at T+1.
- Grant in cycle G (G ≥ T+1) → state is Wait from G+1. master_r_valid_i is accepted from G+1 onward.
- r_valid in cycle R → at R+1: sbdata_valid_o, sbaddress_upd_o or sberror_valid_o pulse; sbbusy_o low; a new trigger is accepted.
- Minimum trigger-to-data latency is 3 cycles.
- dmactive_i low mid-transfer → Idle next cycle, master_req_o drops, no pulses. An outstanding response is ignored.
- rst_ni low → all registers cleared immediately (asynchronous).

## Configuration
- DM_SBA_TIMEOUT_EN defined:
  - A counter runs in Read/Write/Wait states and is cleared on entry from Idle.
  - When it reaches TimeoutCycles: next cycle Idle, master_req_o low, sberror_o = 1 pulse, no increment, and a late r_valid is ignored.
- Undefined: no counter; the block waits indefinitely for gnt/r_valid.

## Test plan
- BusWidth=64, sbaccess=1, address 0x1006, read on address, gnt at T+1, rdata 0xAABB_CCDD_1122_3344 at T+2:
  - be=0xC0 with req at T+1;
  - sbdata_o=0xAABB at T+3;
  - with autoincrement, sbaddress_o=0x1008 and sbaddress_upd_o pulse.
- Write 0x5A with sbaccess=0, address 0x3, BusWidth=32 → be=0x8, wdata=0x5A00_0000, we=1; after r_valid no read pulse and sbbusy_o low.
- sbaccess=3 with BusWidth=32 → sberror_o=4 at T+1, no req. Address 0x2 with sbaccess=2 → sberror_o=3.
- Trigger during WaitRead → sbbusyerror_o pulse; the original read completes with unchanged data and address. Response with r_err=1 → sberror_o=2, no sbdata_valid_o.
- Write and read-on-address triggers in the same cycle → a write only. Address 0xFFFF_FFFC, sbaccess=2, autoincrement → sbaddress_o=0x0.
- DM_SBA_TIMEOUT_EN, TimeoutCycles=16, gnt never asserted → sberror_o=1 at cycle T+17, req low. dmactive_i dropped mid-WaitRead → Idle, no pulses.
